// File: rtl/alu_pkg.sv
// Op codes, FSM states and the single-cycle result mux shared by alu_seq and its interface.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOT  = 4'd5,
    ALU_NEG  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_SLT  = 4'd10,
    ALU_SLTU = 4'd11,
    ALU_CMP  = 4'd12,
    ALU_PASS = 4'd13,
    ALU_MUL  = 4'd14,
    ALU_DIVU = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2
  } alu_state_e;

  // Operands come in widened to 64 bits (a_z zero-extended, a_s sign-extended) so one
  // function serves every DATA_W; the caller keeps the low DATA_W bits of the result.
  function automatic logic [63:0] alu_single(alu_op_e op, logic [63:0] a_z, logic [63:0] a_s,
                                             logic [63:0] b_z, logic [5:0] shamt);
    logic [63:0] r;
    r = '0;
    case (op)
      ALU_ADD:  r = a_z + b_z;
      ALU_SUB:  r = a_z - b_z;
      ALU_AND:  r = a_z & b_z;
      ALU_OR:   r = a_z | b_z;
      ALU_XOR:  r = a_z ^ b_z;
      ALU_NOT:  r = ~a_z;
      ALU_NEG:  r = 64'd0 - a_z;
      ALU_SLL:  r = a_z << shamt;
      ALU_SRL:  r = a_z >> shamt;
      ALU_SRA:  r = $unsigned($signed(a_s) >>> shamt);
      ALU_PASS: r = a_z;
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between the decode stage, alu_seq and writeback.
interface alu_seq_if #(
  parameter int DATA_W = 16
);
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] res_hi;
  logic              t;
  logic              t_we;
  logic              err;
  logic              busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, res, res_hi, t, t_we, err, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, res, res_hi, t, t_we, err, busy
  );

endinterface

// File: rtl/alu_seq_iter.sv
// Iterative datapath shared by MUL (shift-add, LSB first) and DIVU (restoring, MSB first).
// Runs DATA_W steps after start; done flags the final step while lo_nxt/hi_nxt hold the answer.
module alu_seq_iter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run,
`ifdef ALU_SEQ_DIV_EN
  input  logic              div_mode,
`endif
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] lo_nxt,
  output logic [DATA_W-1:0] hi_nxt
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] opnd_q;

  // {hi,lo} is the partial product; the multiplier drains out of lo as product bits shift in.
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] mul_hi;
  logic [DATA_W-1:0] mul_lo;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
  assign mul_hi  = mul_sum[DATA_W:1];
  assign mul_lo  = {mul_sum[0], lo_q[DATA_W-1:1]};

`ifdef ALU_SEQ_DIV_EN
  logic              mode_q;
  logic [DATA_W:0]   rem_sh;
  logic              div_ge;
  logic [DATA_W-1:0] div_sub;
  logic [DATA_W-1:0] div_hi;
  logic [DATA_W-1:0] div_lo;

  // hi is the running remainder, lo shifts the dividend out and the quotient in.
  assign rem_sh  = {hi_q, lo_q[DATA_W-1]};
  assign div_ge  = (rem_sh >= {1'b0, opnd_q});
  assign div_sub = DATA_W'(rem_sh - {1'b0, opnd_q});
  assign div_hi  = div_ge ? div_sub : rem_sh[DATA_W-1:0];
  assign div_lo  = {lo_q[DATA_W-2:0], div_ge};

  always_comb begin
    hi_nxt = mul_hi;
    lo_nxt = mul_lo;
    if (mode_q) begin
      hi_nxt = div_hi;
      lo_nxt = div_lo;
    end
  end
`else
  always_comb begin
    hi_nxt = mul_hi;
    lo_nxt = mul_lo;
  end
`endif

  assign done = run && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
`ifdef ALU_SEQ_DIV_EN
      mode_q <= 1'b0;
`endif
    end else if (start) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= a;
      opnd_q <= b;
`ifdef ALU_SEQ_DIV_EN
      mode_q <= div_mode;
`endif
    end else if (run) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      cnt_q <= done ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: 1-cycle ops, DATA_W-cycle MUL and (with ALU_SEQ_DIV_EN) DATA_W-cycle DIVU.
// in_ready drops while iterating or while an untaken result is held.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  localparam int SHAMT_W = $clog2(DATA_W);

  if (DATA_W < 8 || DATA_W > 64) begin : g_bad_width
    $error("alu_seq: DATA_W must be within 8..64");
  end

  alu_state_e        state_q, state_d;
  alu_op_e           op_e;
  logic              accept, is_mul, is_div, start, iter_done, run;
  logic [DATA_W-1:0] iter_lo, iter_hi;
  logic [DATA_W-1:0] single_res;
  logic              single_t, single_t_we, single_err;
  logic              out_valid_q, t_q, t_we_q, err_q;
  logic [DATA_W-1:0] res_q, res_hi_q;

  assign op_e         = alu_op_e'(bus.op);
  assign bus.in_ready = !rst && (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_mul       = (op_e == ALU_MUL);
`ifdef ALU_SEQ_DIV_EN
  assign is_div       = (op_e == ALU_DIVU);
`else
  assign is_div       = 1'b0;
`endif
  assign start        = accept && (is_mul || is_div);
  assign run          = (state_q != ST_IDLE);

  always_comb begin
    single_res  = DATA_W'(alu_single(op_e, 64'(bus.a), 64'($signed(bus.a)), 64'(bus.b),
                                     6'(bus.b[SHAMT_W-1:0])));
    single_t    = 1'b0;
    single_t_we = 1'b0;
    single_err  = 1'b0;
    case (op_e)
      ALU_SLT: begin
        single_t    = ($signed(bus.a) < $signed(bus.b));
        single_t_we = 1'b1;
      end
      ALU_SLTU: begin
        single_t    = (bus.a < bus.b);
        single_t_we = 1'b1;
      end
      ALU_CMP: begin
        single_t    = (bus.a != bus.b);
        single_t_we = 1'b1;
      end
`ifndef ALU_SEQ_DIV_EN
      ALU_DIVU: single_err = 1'b1;
`endif
      default: ;
    endcase
  end

  alu_seq_iter #(
    .DATA_W(DATA_W)
  ) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .run     (run),
`ifdef ALU_SEQ_DIV_EN
    .div_mode(is_div),
`endif
    .a       (bus.a),
    .b       (bus.b),
    .done    (iter_done),
    .lo_nxt  (iter_lo),
    .hi_nxt  (iter_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:                if (start) state_d = is_div ? ST_DIV_RUN : ST_MUL_RUN;
      ST_MUL_RUN, ST_DIV_RUN: if (iter_done) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // A multi-cycle accept needs no branch: in_ready already guaranteed the old result is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      res_hi_q    <= '0;
      t_q         <= 1'b0;
      t_we_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept && !start) begin
      out_valid_q <= 1'b1;
      res_q       <= single_res;
      res_hi_q    <= '0;
      t_q         <= single_t;
      t_we_q      <= single_t_we;
      err_q       <= single_err;
    end else if (iter_done) begin
      out_valid_q <= 1'b1;
      res_q       <= iter_lo;
      res_hi_q    <= iter_hi;
      t_q         <= 1'b0;
      t_we_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.t         = t_q;
  assign bus.t_we      = t_we_q;
  assign bus.err       = err_q;
  assign bus.busy      = run;

endmodule
